drv_keypad_scan: RTL and testbench
==================================

DRV_KEYPAD_SCAN -- requirements
Module: drv_keypad_scan

Interface
REQ-001 Parameter p_height, default 4: number of matrix rows (driven lines).
REQ-002 Parameter p_width, default 4: number of matrix columns (sensed lines).
REQ-003 Parameter p_scale, default 5: row settle time is 2^p_scale clocks.
REQ-004 Parameter p_mode, default "pullup": "pullup" means active row and pressed column are low; any other value means active-high.
REQ-005 Parameter p_debounce, default 3: consecutive differing samples needed to accept a key change; minimum 1.
REQ-006 Parameter p_depth, default 4: event FIFO depth; must be a power of two.
REQ-007 i_clk  input  1  the single clock.
REQ-008 i_rst  input  1  reset, asynchronous and active-high.
REQ-009 o_row  output  p_height  row drive, one-hot active (polarity per p_mode).
REQ-010 i_col  input  p_width  column sense (polarity per p_mode).
REQ-011 o_valid  output  1  event available at FIFO head.
REQ-012 i_ready  input  1  consumer accepts the head event.
REQ-013 o_code  output  1+clog2(p_height)+clog2(p_width)  event code {release, row, col}; release=1 for release, 0 for press.
REQ-014 o_state  output  p_height*p_width  debounced pressed map; bit index is row*p_width+col.
REQ-015 o_overflow  output  1  sticky flag: an event was dropped.

Function
REQ-016 The FSM SHALL have three states: ST_SETTLE, ST_SAMPLE and ST_EMIT.
REQ-017 ST_SETTLE SHALL drive the current row and count 2^p_scale clocks, then go to ST_SAMPLE.
REQ-018 ST_SAMPLE SHALL last 1 clock: it registers i_col (normalized to 1=pressed) and updates the debounce counters of every key in the row.
REQ-019 Debounce: a raw sample equal to the stable value SHALL clear that key's counter; a differing sample SHALL increment it.
REQ-020 Debounce acceptance: when a differing sample brings the counter to p_debounce, the stable bit SHALL toggle, the counter SHALL clear and the key SHALL be marked changed.
REQ-021 ST_EMIT SHALL visit columns 0..p_width-1, one per clock, pushing one event for each changed column in ascending column order, then advance the row and return to ST_SETTLE.
REQ-022 Row index SHALL wrap from p_height-1 to 0, so the full scan period is p_height*(2^p_scale+1+p_width) clocks.
REQ-023 o_state SHALL update in the ST_SAMPLE clock of acceptance, independent of the FIFO.
REQ-024 A push into a full FIFO SHALL be dropped and set o_overflow; o_overflow is cleared only by reset.
REQ-025 If push and pop occur in the same clock while the FIFO is full, the pop SHALL take effect first and the push SHALL be accepted.
REQ-026 o_valid=1 exactly when the FIFO is non-empty, and o_code SHALL equal the head entry.
REQ-027 Pop SHALL occur on o_valid&&i_ready; i_ready while the FIFO is empty SHALL be ignored.
REQ-028 Keys in non-driven rows SHALL be untouched; their counters are held.

Reset
REQ-029 i_rst SHALL asynchronously force: FSM=ST_SETTLE, row index 0, settle counter 0, all counters 0, o_state 0, FIFO empty, o_valid 0, o_code 0, o_overflow 0.
REQ-030 o_row SHALL be all-inactive while i_rst is high; row 0 is driven from the first clock after deassertion.
REQ-031 Reset mid-scan or mid-emit SHALL discard pending events and partial debounce progress.

Structure
REQ-032 Package drv_keypad_pkg SHALL hold the FSM state enum and the code-width constant functions.
REQ-033 The event FIFO SHALL be the sub-module drv_keypad_fifo (parameters: width, depth; ports: push/pop/full/empty/head).

Verification
Bench parameters for all scenarios: p_height=4, p_width=4, p_scale=2, p_debounce=3, p_depth=4, pullup.
REQ-034 Hold key (1,2) pressed -> after the 3rd row-1 sample, o_state[6]=1 and one event o_code=5'b0_01_10.
REQ-035 Key (0,0) bounces, alternating on each row-0 sample -> no events and o_state[0] stays 0.
REQ-036 Press (2,0) and (2,3) together -> events 5'b0_10_00 then 5'b0_10_11 on consecutive pops.
REQ-037 Hold i_ready=0 and create 5 events -> 4 buffered, o_overflow=1, o_state correct; then i_ready=1 -> 4 pops in order.
REQ-038 Release key (1,2) after REQ-034 -> event 5'b1_01_10 and o_state[6]=0.
REQ-039 Assert i_rst during ST_EMIT -> all outputs at reset values immediately; scanning restarts at row 0.

Source files
------------

// File: rtl/drv_keypad_pkg.sv
// Shared types and width helpers for the keypad scanner and its event FIFO.
package drv_keypad_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_EMIT
  } state_t;

  // Index width for n items; never narrower than one bit so a single row/column still has a field.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned code_bits(input int unsigned height, input int unsigned width);
    return 1 + idx_bits(height) + idx_bits(width);
  endfunction

endpackage

// File: rtl/drv_keypad_fifo.sv
// Event FIFO: a pop into a full FIFO frees the slot for a push in the same clock.
module drv_keypad_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] head
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned NW = $clog2(depth + 1);

  logic [depth-1:0][width-1:0] mem;
  logic [AW-1:0]               wptr;
  logic [AW-1:0]               rptr;
  logic [NW-1:0]               count;
  logic                        do_push;
  logic                        do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == NW'(depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= data;
        wptr      <= bump(wptr);
      end
      if (do_pop) begin
        rptr <= bump(rptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/drv_keypad_scan.sv
// Keypad matrix scanner: settle a row, sample its columns with per-key debounce, then emit
// press/release events for that row into a FIFO.
module drv_keypad_scan
  import drv_keypad_pkg::*;
#(
  parameter int unsigned p_height   = 4,
  parameter int unsigned p_width    = 4,
  parameter int unsigned p_scale    = 5,
  parameter              p_mode     = "pullup",
  parameter int unsigned p_debounce = 3,
  parameter int unsigned p_depth    = 4,
  localparam int unsigned CW        = code_bits(p_height, p_width)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  output logic [p_height-1:0]         o_row,
  input  logic [p_width-1:0]          i_col,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [CW-1:0]               o_code,
  output logic [p_height*p_width-1:0] o_state,
  output logic                        o_overflow
);

  localparam bit          PULLUP = (p_mode == "pullup");
  localparam int unsigned RW     = idx_bits(p_height);
  localparam int unsigned CLW    = idx_bits(p_width);
  localparam int unsigned KEYS   = p_height * p_width;
  localparam int unsigned KW     = idx_bits(KEYS);
  localparam int unsigned DW     = $clog2(p_debounce + 1);
  localparam int unsigned SW     = p_scale + 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'((1 << p_scale) - 1);

  state_t                   state;
  logic [RW-1:0]            row;
  logic [CLW-1:0]           col;
  logic [SW-1:0]            settle;
  logic [p_width-1:0]       changed;
  logic [KEYS-1:0]          stable;
  logic [KEYS-1:0][DW-1:0]  cnt;
  logic                     row_en;
  logic                     overflow;

  logic [p_width-1:0]          sense;
  logic [KW-1:0]               row_base;
  logic [p_width-1:0]          accept;
  logic [p_width-1:0]          nxt_stab;
  logic [p_width-1:0][DW-1:0]  nxt_cnt;
  logic [p_height-1:0]         onehot;
  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [CW-1:0]               push_code;

  assign sense    = PULLUP ? ~i_col : i_col;
  assign row_base = KW'(32'(row) * p_width);

  // Debounce step for every key of the driven row; only applied during ST_SAMPLE.
  always_comb begin
    accept   = '0;
    nxt_stab = '0;
    nxt_cnt  = '0;
    for (int unsigned c = 0; c < p_width; c++) begin
      nxt_stab[c] = stable[row_base + KW'(c)];
      if (sense[c] == stable[row_base + KW'(c)]) begin
        nxt_cnt[c] = '0;
      end else if (cnt[row_base + KW'(c)] == DW'(p_debounce - 1)) begin
        nxt_cnt[c]  = '0;
        nxt_stab[c] = ~stable[row_base + KW'(c)];
        accept[c]   = 1'b1;
      end else begin
        nxt_cnt[c] = cnt[row_base + KW'(c)] + 1'b1;
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int unsigned r = 0; r < p_height; r++) begin
      onehot[r] = (row == RW'(r));
    end
  end

  assign o_row = row_en ? (PULLUP ? ~onehot : onehot) : (PULLUP ? '1 : '0);

  assign push      = (state == ST_EMIT) && changed[col];
  assign push_code = {~stable[row_base + KW'(col)], row, col};
  assign pop       = !empty && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_SETTLE;
      row      <= '0;
      col      <= '0;
      settle   <= '0;
      changed  <= '0;
      stable   <= '0;
      cnt      <= '0;
      row_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      row_en <= 1'b1;
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      case (state)
        ST_SETTLE: begin
          if (settle == SETTLE_LAST) begin
            settle <= '0;
            state  <= ST_SAMPLE;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        ST_SAMPLE: begin
          for (int unsigned c = 0; c < p_width; c++) begin
            stable[row_base + KW'(c)] <= nxt_stab[c];
            cnt[row_base + KW'(c)]    <= nxt_cnt[c];
          end
          changed <= accept;
          col     <= '0;
          state   <= ST_EMIT;
        end
        ST_EMIT: begin
          if (col == CLW'(p_width - 1)) begin
            col     <= '0;
            changed <= '0;
            row     <= (row == RW'(p_height - 1)) ? '0 : row + 1'b1;
            state   <= ST_SETTLE;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end

  drv_keypad_fifo #(
    .width (CW),
    .depth (p_depth)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .data  (push_code),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (o_code)
  );

  assign o_valid    = !empty;
  assign o_state    = stable;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_drv_keypad_scan.sv
// Directed bench for drv_keypad_scan with a 4x4 pull-up key matrix model.
module tb_drv_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        valid;
  logic        ready;
  logic [4:0]  code;
  logic [15:0] state;
  logic        ovf;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  drv_keypad_scan #(
    .p_height   (4),
    .p_width    (4),
    .p_scale    (2),
    .p_mode     ("pullup"),
    .p_debounce (3),
    .p_depth    (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_row      (row),
    .i_col      (col),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_code     (code),
    .o_state    (state),
    .o_overflow (ovf)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pop_one();
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic sync_row0(output bit ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = row;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (row == 4'b1110 && prev != 4'b1110) begin
        ok = 1'b1;
        break;
      end
      prev = row;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ready = 1'b0;
    keys  = '0;
    repeat (2) @(negedge clk);
    checks++; if (row !== 4'hF)  begin failures++; $display("FAIL reset_row got=%b exp=1111", row); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (code !== 5'd0)  begin failures++; $display("FAIL reset_code got=%b exp=00000", code); end
    checks++; if (state !== 16'h0) begin failures++; $display("FAIL reset_state got=%h exp=0000", state); end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL reset_row0 got=%b exp=1110", row); end
  endtask

  task automatic test_press();
    int n;
    keys    = '0;
    keys[6] = 1'b1;
    do_reset();
    wait_valid(200, n);
    checks++; if (n !== 89) begin failures++; $display("FAIL press_latency got=%0d exp=89", n); end
    checks++; if (code !== 5'b0_01_10) begin failures++; $display("FAIL press_code got=%b exp=00110", code); end
    checks++; if (state !== 16'h0040) begin failures++; $display("FAIL press_state got=%h exp=0040", state); end
    pop_one();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL press_drain got=%b exp=0", valid); end
  endtask

  task automatic test_release();
    int n;
    keys[6] = 1'b0;
    wait_valid(150, n);
    checks++; if (n < 0) begin failures++; $display("FAIL release_timeout got=%0d exp=>0", n); end
    checks++; if (code !== 5'b1_01_10) begin failures++; $display("FAIL release_code got=%b exp=10110", code); end
    checks++; if (state !== 16'h0000) begin failures++; $display("FAIL release_state got=%h exp=0000", state); end
    pop_one();
  endtask

  task automatic test_bounce();
    logic [3:0] prev;
    int toggles = 0;
    bit bad = 1'b0;
    prev = row;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (row == 4'b1110 && prev != 4'b1110) begin
        keys[0] = ~keys[0];
        toggles++;
      end
      prev = row;
      if (valid || state[0]) bad = 1'b1;
    end
    keys[0] = 1'b0;
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL bounce_quiet got=%b exp=0", bad); end
    checks++; if (toggles < 6) begin failures++; $display("FAIL bounce_toggles got=%0d exp=>=6", toggles); end
  endtask

  task automatic test_two_keys();
    int n;
    keys[8]  = 1'b1;
    keys[11] = 1'b1;
    wait_valid(150, n);
    checks++; if (code !== 5'b0_10_00) begin failures++; $display("FAIL two_first got=%b exp=01000 n=%0d", code, n); end
    pop_one();
    wait_valid(10, n);
    checks++; if (code !== 5'b0_10_11) begin failures++; $display("FAIL two_second got=%b exp=01011 n=%0d", code, n); end
    checks++; if (state !== 16'h0900) begin failures++; $display("FAIL two_state got=%h exp=0900", state); end
    pop_one();
    keys[8]  = 1'b0;
    keys[11] = 1'b0;
    wait_valid(150, n);
    checks++; if (code !== 5'b1_10_00) begin failures++; $display("FAIL two_rel_first got=%b exp=11000 n=%0d", code, n); end
    pop_one();
    wait_valid(10, n);
    checks++; if (code !== 5'b1_10_11) begin failures++; $display("FAIL two_rel_second got=%b exp=11011 n=%0d", code, n); end
    pop_one();
    checks++; if (state !== 16'h0000) begin failures++; $display("FAIL two_rel_state got=%h exp=0000", state); end
  endtask

  task automatic test_overflow();
    logic [4:0] exp_codes [4];
    bit ok;
    int n = -1;
    exp_codes[0] = 5'b0_00_01;
    exp_codes[1] = 5'b0_11_00;
    exp_codes[2] = 5'b0_11_01;
    exp_codes[3] = 5'b0_11_10;
    ready = 1'b0;
    sync_row0(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ovf_sync got=%b exp=1", ok); end
    keys = 16'hF002;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (ovf) begin
        n = i;
        break;
      end
    end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1 n=%0d", ovf, n); end
    checks++; if (state !== 16'hF002) begin failures++; $display("FAIL ovf_state got=%h exp=f002", state); end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid !== 1'b1 || code !== exp_codes[i]) begin
        failures++;
        $display("FAIL ovf_pop%0d got=%b/%b exp=1/%b", i, valid, code, exp_codes[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", valid); end
  endtask

  task automatic test_reset_mid_emit();
    bit ok;
    int n;
    sync_row0(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_sync got=%b exp=1", ok); end
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (row !== 4'hF)   begin failures++; $display("FAIL mid_row got=%b exp=1111", row); end
    checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL mid_valid got=%b exp=0", valid); end
    checks++; if (code !== 5'd0)   begin failures++; $display("FAIL mid_code got=%b exp=00000", code); end
    checks++; if (state !== 16'h0) begin failures++; $display("FAIL mid_state got=%h exp=0000", state); end
    checks++; if (ovf !== 1'b0)    begin failures++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (row !== 4'b1110) begin failures++; $display("FAIL mid_row0 got=%b exp=1110", row); end
    wait_valid(150, n);
    checks++; if (n !== 78) begin failures++; $display("FAIL mid_latency got=%0d exp=78", n); end
    checks++; if (code !== 5'b0_00_01) begin failures++; $display("FAIL mid_code_after got=%b exp=00001", code); end
    checks++; if (state !== 16'h0002) begin failures++; $display("FAIL mid_state_after got=%h exp=0002", state); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_two_keys();
    test_overflow();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
